// File: rtl/acc_write_arbiter.sv
// Write sequencer/arbiter for the 16-bit accumulator: A/B requesters plus clear, 3-phase writes.
// Optional build macro ACC_ARB_RR_EN selects round-robin arbitration (default: A over B).
module acc_write_arbiter #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [DATA_W-1:0] acc_data,
  output logic              acc_str,
  output logic              acc_clr,
  output logic              busy,
  output logic              last_grant
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StClear
  } state_e;

  state_e state_q;
  logic   grant_a;
  logic   grant_b;

  // Grants are only offered in IDLE; a pending clear or reset suppresses both.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == StIdle && !reset && !clr_req) begin
`ifdef ACC_ARB_RR_EN
      grant_a = a_valid && (!b_valid || last_grant);
      grant_b = b_valid && (!a_valid || !last_grant);
`else
      grant_a = a_valid;
      grant_b = b_valid && !a_valid;
`endif
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      acc_data   <= '0;
      acc_str    <= 1'b0;
      acc_clr    <= 1'b0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      acc_str <= 1'b0;
      acc_clr <= 1'b0;
      case (state_q)
        StIdle: begin
          if (clr_req) begin
            state_q <= StClear;
            acc_clr <= 1'b1;
            busy    <= 1'b1;
          end else if (grant_a || grant_b) begin
            state_q    <= StSetup;
            busy       <= 1'b1;
            acc_data   <= grant_b ? b_data : a_data;
            last_grant <= grant_b;
          end
        end
        StSetup: begin
          state_q <= StStrobe;
          acc_str <= 1'b1;
        end
        StStrobe: begin
          state_q <= StHold;
        end
        StHold: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        StClear: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_write_arbiter.sv
// Scoreboard bench for acc_write_arbiter: cycle-level reference model plus event queues.
module tb_acc_write_arbiter;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset, clr_req, a_valid, b_valid;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready, acc_str, acc_clr, busy, last_grant;
  logic [W-1:0] acc_data;

  acc_write_arbiter #(.DATA_W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .clr_req    (clr_req),
    .a_valid    (a_valid),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .acc_data   (acc_data),
    .acc_str    (acc_str),
    .acc_clr    (acc_clr),
    .busy       (busy),
    .last_grant (last_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    logic [W-1:0] data;
  } ev_t;

  ev_t str_q[$];
  int  clr_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  logic a_xfer = 1'b0, b_xfer = 1'b0, win = 1'b0;
  int  win_a = 0, win_b = 0;

  // Reference model state: remaining busy cycles, last grant, data held at the accumulator.
  int           m_cnt = 0;
  logic         m_lg = 1'b1;
  logic [W-1:0] m_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Model: predicts readies/busy/data every cycle and schedules strobe/clear events.
  initial forever begin
    logic exp_a, exp_b, pickb;
    @(negedge clk);
    exp_a = 1'b0;
    exp_b = 1'b0;
    pickb = 1'b0;
    if (!reset && m_cnt == 0 && !clr_req) begin
`ifdef ACC_ARB_RR_EN
      pickb = b_valid && (!a_valid || !m_lg);
`else
      pickb = b_valid && !a_valid;
`endif
      exp_b = pickb;
      exp_a = a_valid && !pickb;
    end
    chk("a_ready", 32'(a_ready), 32'(exp_a));
    chk("b_ready", 32'(b_ready), 32'(exp_b));
    chk("busy", 32'(busy), 32'(m_cnt != 0));
    chk("acc_data", 32'(acc_data), 32'(m_data));
    chk("last_grant", 32'(last_grant), 32'(m_lg));
    if (reset) begin
      m_cnt  = 0;
      m_lg   = 1'b1;
      m_data = '0;
      while (str_q.size() > 0 && str_q[$].due > cyc) void'(str_q.pop_back());
      while (clr_q.size() > 0 && clr_q[$] > cyc) void'(clr_q.pop_back());
    end else if (m_cnt != 0) begin
      m_cnt--;
    end else if (clr_req) begin
      clr_q.push_back(cyc + 1);
      m_cnt = 1;
    end else if (exp_a || exp_b) begin
      m_data = exp_b ? b_data : a_data;
      m_lg   = exp_b;
      str_q.push_back('{due: cyc + 2, data: m_data});
      m_cnt  = 3;
    end
    a_xfer = a_valid && a_ready;
    b_xfer = b_valid && b_ready;
    if (win && a_xfer) win_a++;
    if (win && b_xfer) win_b++;
  end

  // Monitor: pops expected events whenever the DUT strobes store or clear.
  initial forever begin
    @(negedge clk);
    while (str_q.size() > 0 && str_q[0].due < cyc) begin
      total++;
      bad++;
      $display("FAIL acc_str_missing at cycle %0d: got 0 expected 1 (due %0d)", cyc, str_q[0].due);
      void'(str_q.pop_front());
    end
    while (clr_q.size() > 0 && clr_q[0] < cyc) begin
      total++;
      bad++;
      $display("FAIL acc_clr_missing at cycle %0d: got 0 expected 1 (due %0d)", cyc, clr_q[0]);
      void'(clr_q.pop_front());
    end
    if (acc_str !== 1'b0) begin
      if (str_q.size() > 0 && str_q[0].due == cyc) begin
        chk("acc_str_data", 32'(acc_data), 32'(str_q[0].data));
        void'(str_q.pop_front());
      end else begin
        total++;
        bad++;
        $display("FAIL acc_str_unexpected at cycle %0d: got %b expected 0", cyc, acc_str);
      end
    end
    if (acc_clr !== 1'b0) begin
      if (clr_q.size() > 0 && clr_q[0] == cyc) begin
        total++;
        void'(clr_q.pop_front());
      end else begin
        total++;
        bad++;
        $display("FAIL acc_clr_unexpected at cycle %0d: got %b expected 0", cyc, acc_clr);
      end
    end
  end

  initial begin
    reset = 1'b1; clr_req = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    step();
    step();
    chk("rst_acc_data", 32'(acc_data), 32'h0);
    chk("rst_acc_str", 32'(acc_str), 32'h0);
    chk("rst_acc_clr", 32'(acc_clr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_last_grant", 32'(last_grant), 32'h1);
    chk("rst_a_ready", 32'(a_ready), 32'h0);
    chk("rst_b_ready", 32'(b_ready), 32'h0);
    reset = 1'b0;
    repeat (2) step();

    // Single A write, then a second one at T+4.
    a_valid = 1'b1; a_data = 16'hFFFF;
    step(); a_valid = 1'b0;
    step(); step(); step();
    a_valid = 1'b1; a_data = 16'h1234;
    step(); a_valid = 1'b0;
    repeat (5) step();

    // Contention from a fresh reset so A wins first.
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    win = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_data = 16'hFF01; b_data = 16'h0FFF;
    repeat (16) step();
    win = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
`ifdef ACC_ARB_RR_EN
    chk("contend_a_grants", 32'(win_a), 32'd2);
    chk("contend_b_grants", 32'(win_b), 32'd2);
`else
    chk("contend_a_grants", 32'(win_a), 32'd4);
    chk("contend_b_grants", 32'(win_b), 32'd0);
`endif
    repeat (5) step();

    // Clear and A in the same idle cycle.
    clr_req = 1'b1; a_valid = 1'b1; a_data = 16'h0123;
    step(); clr_req = 1'b0;
    step();
    step(); a_valid = 1'b0;
    repeat (6) step();

    // Reset during the strobe cycle.
    a_valid = 1'b1; a_data = 16'h0FFF;
    step(); a_valid = 1'b0;
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_acc_str", 32'(acc_str), 32'h0);
    chk("abort_acc_data", 32'(acc_data), 32'h0);
    repeat (6) step();

    // B raised during HOLD of an A write.
    a_valid = 1'b1; a_data = 16'h5A5A;
    step(); a_valid = 1'b0;
    step(); step();
    b_valid = 1'b1; b_data = 16'hBEEF;
    step(); step(); b_valid = 1'b0;
    repeat (5) step();

    // Randomized traffic with protocol-abiding requesters.
    for (int i = 0; i < 3000; i++) begin
      if (a_xfer) a_valid = 1'b0;
      if (b_xfer) b_valid = 1'b0;
      if (!a_valid && $urandom_range(0, 2) == 0) begin
        a_valid = 1'b1;
        a_data  = 16'($urandom);
      end
      if (!b_valid && $urandom_range(0, 2) == 0) begin
        b_valid = 1'b1;
        b_data  = 16'($urandom);
      end
      clr_req = ($urandom_range(0, 15) == 0);
      reset   = ($urandom_range(0, 249) == 0);
      step();
    end

    reset = 1'b0; clr_req = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    repeat (8) step();
    chk("events_drained", 32'(str_q.size() + clr_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
